// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared types and constants for the RGB/RAW video stream blocks.
//   bayer_phase_e  : 2-bit CFA pattern code (colour at r0c0 / r0c1 / r1c0 / r1c1)
//   stream_state_e : line-framing FSM states used by video_stream_tracker
//   color_e        : colour plane selected for a RAW sample
//   beat_info_t    : per-beat decode produced by the stream tracker
//   cnt_width()    : counter width helper that never returns 0
//   bayer_color()  : colour plane for a given pattern and row/column parity
// -----------------------------------------------------------------------------
package video_pkg;

  // Defaults shared with the demosaic path.
  localparam int unsigned DEFAULT_LINE_WIDTH  = 1280;
  localparam int unsigned DEFAULT_FRAME_LINES = 720;

  typedef enum logic [1:0] {
    BAYER_RGGB = 2'd0,
    BAYER_GRBG = 2'd1,
    BAYER_GBRG = 2'd2,
    BAYER_BGGR = 2'd3
  } bayer_phase_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no line seen since reset or since the end of a frame
    S_LINE = 2'd1,  // line open
    S_GAP  = 2'd2   // between lines of a frame
  } stream_state_e;

  typedef enum logic [1:0] {
    COLOR_R = 2'd0,
    COLOR_G = 2'd1,
    COLOR_B = 2'd2
  } color_e;

  // Decode of one input beat. accept/sop/eop describe the pixel that is
  // forwarded; the error and frame flags may be set for a dropped beat too.
  typedef struct packed {
    logic accept;
    logic sop;
    logic eop;
    logic row_par;
    logic col_par;
    logic err_len;
    logic err_sop;
    logic frame_done;
  } beat_info_t;

  // A one-line frame would otherwise give a zero-width line counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // XOR-ing the pattern code into {row, col} parity reduces every pattern to
  // RGGB: 00 -> R, 11 -> B, mixed parity -> G.
  function automatic color_e bayer_color(input logic [1:0] pattern,
                                         input logic       row_par,
                                         input logic       col_par);
    logic [1:0] p;
    p = {row_par, col_par} ^ pattern;
    case (p)
      2'b00:   return COLOR_R;
      2'b11:   return COLOR_B;
      default: return COLOR_G;
    endcase
  endfunction

endpackage

// File: rtl/video_stream_tracker.sv
// -----------------------------------------------------------------------------
// video_stream_tracker
// Follows sop/eop framing of a pixel stream, keeps column and line position,
// and classifies every input beat. The beat decode is combinational so the
// caller can register it alongside its own data path.
//   clk, reset     : clock, synchronous active-high reset
//   valid_i        : pixel qualifier
//   sop_i, eop_i   : first / last pixel of a line (qualified by valid_i)
//   beat_o         : decode of the current beat (accept, framing, parity,
//                    err_len, err_sop, frame_done)
// -----------------------------------------------------------------------------
module video_stream_tracker
  import video_pkg::*;
#(
  parameter int unsigned LINE_WIDTH  = DEFAULT_LINE_WIDTH,
  parameter int unsigned FRAME_LINES = DEFAULT_FRAME_LINES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic       sop_i,
  input  logic       eop_i,
  output beat_info_t beat_o
);

  localparam int unsigned CW = cnt_width(LINE_WIDTH + 1);
  localparam int unsigned LW = cnt_width(FRAME_LINES);

  localparam logic [CW-1:0] COL_LAST  = CW'(LINE_WIDTH - 1);
  localparam logic [CW-1:0] COL_END   = CW'(LINE_WIDTH);
  localparam logic [LW-1:0] LINE_LAST = LW'(FRAME_LINES - 1);
  localparam logic          ONE_WIDE  = (LINE_WIDTH == 1);

  stream_state_e state_q, state_d;
  logic [CW-1:0] col_q,   col_d;
  logic [LW-1:0] line_q,  line_d;
  // Set once an overrun has been reported so the line raises err_len only once.
  logic          ovr_q,   ovr_d;

  logic          line_is_last;
  logic [LW-1:0] line_next;

  assign line_is_last = (line_q == LINE_LAST);
  assign line_next    = line_is_last ? '0 : line_q + LW'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      line_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      ovr_q   <= ovr_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    ovr_d   = ovr_q;
    beat_o  = '0;

    if (valid_i) begin
      if (sop_i) begin
        // A sop always starts a line at column 0 on the current row; inside
        // an open line it abandons that line without advancing line_cnt.
        beat_o.accept  = 1'b1;
        beat_o.sop     = 1'b1;
        beat_o.row_par = line_q[0];
        beat_o.col_par = 1'b0;
        beat_o.err_sop = (state_q == S_LINE);
        ovr_d          = 1'b0;
        if (eop_i) begin
          beat_o.eop        = 1'b1;
          beat_o.err_len    = !ONE_WIDE;
          beat_o.frame_done = line_is_last;
          line_d            = line_next;
          col_d             = '0;
          state_d           = line_is_last ? S_IDLE : S_GAP;
        end else begin
          col_d   = CW'(1);
          state_d = S_LINE;
        end
      end else if (state_q != S_LINE) begin
        // Pixel outside a line: dropped.
        beat_o.err_sop = 1'b1;
      end else if (col_q == COL_END) begin
        // Column overrun: drop the pixel, report once, but still let eop
        // close the line so the frame keeps its line count.
        beat_o.err_len = !ovr_q;
        ovr_d          = 1'b1;
        if (eop_i) begin
          beat_o.frame_done = line_is_last;
          line_d            = line_next;
          col_d             = '0;
          ovr_d             = 1'b0;
          state_d           = line_is_last ? S_IDLE : S_GAP;
        end
      end else begin
        beat_o.accept  = 1'b1;
        beat_o.row_par = line_q[0];
        beat_o.col_par = col_q[0];
        if (eop_i) begin
          beat_o.eop        = 1'b1;
          beat_o.err_len    = (col_q != COL_LAST);
          beat_o.frame_done = line_is_last;
          line_d            = line_next;
          col_d             = '0;
          state_d           = line_is_last ? S_IDLE : S_GAP;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rgb2raw_bayer_mosaic.sv
// -----------------------------------------------------------------------------
// rgb2raw_bayer_mosaic
// Re-mosaics an RGB pixel stream into a single-channel Bayer RAW stream.
// Two-stage pipeline: stage 1 registers the components and the tracker's
// beat decode, stage 2 registers the colour mux and regenerated framing.
//   clk, reset                : clock, synchronous active-high reset
//   r_data, g_data, b_data    : colour components
//   data_valid, sop, eop      : input pixel qualifier and line framing
//   raw_data, raw_valid       : Bayer sample and qualifier
//   raw_sop, raw_eop          : regenerated line framing
//   frame_done                : pulse when the last line of a frame closes
//   err_len, err_sop          : malformed-line pulses
// -----------------------------------------------------------------------------
module rgb2raw_bayer_mosaic
  import video_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned LINE_WIDTH  = DEFAULT_LINE_WIDTH,
  parameter int unsigned FRAME_LINES = DEFAULT_FRAME_LINES,
  parameter logic [1:0]  BAYER_PHASE = BAYER_RGGB
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [DATA_WIDTH-1:0] g_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  data_valid,
  input  logic                  sop,
  input  logic                  eop,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic                  raw_valid,
  output logic                  raw_sop,
  output logic                  raw_eop,
  output logic                  frame_done,
  output logic                  err_len,
  output logic                  err_sop
);

  beat_info_t beat;

  video_stream_tracker #(
    .LINE_WIDTH  (LINE_WIDTH),
    .FRAME_LINES (FRAME_LINES)
  ) u_tracker (
    .clk     (clk),
    .reset   (reset),
    .valid_i (data_valid),
    .sop_i   (sop),
    .eop_i   (eop),
    .beat_o  (beat)
  );

  // ---------------------------------------------------------------------------
  // Stage 1: components and beat decode
  // ---------------------------------------------------------------------------
  beat_info_t            s1_beat_q;
  logic [DATA_WIDTH-1:0] s1_r_q, s1_g_q, s1_b_q;

  // NOTE: the data registers are reset as well as the control flags; raw_data
  // is an output and must read 0 after reset, not whatever was in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_beat_q <= '0;
      s1_r_q    <= '0;
      s1_g_q    <= '0;
      s1_b_q    <= '0;
    end else begin
      s1_beat_q <= beat;
      if (beat.accept) begin
        s1_r_q <= r_data;
        s1_g_q <= g_data;
        s1_b_q <= b_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour mux and output framing
  // ---------------------------------------------------------------------------
  color_e                s1_color;
  logic [DATA_WIDTH-1:0] raw_data_d;

  assign s1_color = bayer_color(BAYER_PHASE, s1_beat_q.row_par, s1_beat_q.col_par);

  always_comb begin
    raw_data_d = s1_g_q;
    case (s1_color)
      COLOR_R: raw_data_d = s1_r_q;
      COLOR_B: raw_data_d = s1_b_q;
      default: raw_data_d = s1_g_q;
    endcase
  end

  logic [DATA_WIDTH-1:0] raw_data_q;
  logic                  raw_valid_q, raw_sop_q, raw_eop_q;
  logic                  frame_done_q, err_len_q, err_sop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_data_q   <= '0;
      raw_valid_q  <= 1'b0;
      raw_sop_q    <= 1'b0;
      raw_eop_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_len_q    <= 1'b0;
      err_sop_q    <= 1'b0;
    end else begin
      // raw_data holds its last sample while raw_valid is low.
      if (s1_beat_q.accept) begin
        raw_data_q <= raw_data_d;
      end
      raw_valid_q  <= s1_beat_q.accept;
      raw_sop_q    <= s1_beat_q.sop;
      raw_eop_q    <= s1_beat_q.eop;
      frame_done_q <= s1_beat_q.frame_done;
      err_len_q    <= s1_beat_q.err_len;
      err_sop_q    <= s1_beat_q.err_sop;
    end
  end

  assign raw_data   = raw_data_q;
  assign raw_valid  = raw_valid_q;
  assign raw_sop    = raw_sop_q;
  assign raw_eop    = raw_eop_q;
  assign frame_done = frame_done_q;
  assign err_len    = err_len_q;
  assign err_sop    = err_sop_q;

endmodule
